// File: rtl/exec_muldiv.sv
// Iterative radix-2 MULT/MULTU/DIV/DIVU unit holding the HI/LO registers.
// Optional MULDIV_EARLY_OUT_EN: multiplies finish once the remaining multiplier bits are zero.
module exec_muldiv #(
   parameter int WIDTH = 32
) (
   input  logic             CLK,
   input  logic             nRST,
   input  logic             en,
   input  logic             flush,
   input  logic             start,
   input  logic [1:0]       op,
   input  logic [WIDTH-1:0] port_a,
   input  logic [WIDTH-1:0] port_b,
   input  logic             hi_we,
   input  logic             lo_we,
   input  logic [WIDTH-1:0] wdat,
   output logic             busy,
   output logic             done,
   output logic [WIDTH-1:0] hi,
   output logic [WIDTH-1:0] lo
);
   localparam int CW = $clog2(WIDTH + 1);
   typedef enum logic [1:0] {IDLE = 2'd0, CALC = 2'd1, FIX = 2'd2, DONE = 2'd3} state_t;

   state_t             state_r;
   logic [CW-1:0]      cnt_r;
   logic [1:0]         op_r;
   logic [2*WIDTH-1:0] acc_r;
   logic [2*WIDTH-1:0] mcand_r;
   logic [WIDTH-1:0]   mplier_r;
   logic [WIDTH-1:0]   a_raw_r;
   logic               neg_q_r, neg_r_r, div0_r;
   logic               busy_r, done_r;
   logic [WIDTH-1:0]   hi_r, lo_r;

   logic               idle_like_s, accept_s, signed_s, last_s;
   logic [WIDTH-1:0]   a_abs_s, b_abs_s;
   logic [2*WIDTH-1:0] step_s;
   logic [WIDTH:0]     shifted_s, diff_s;
   logic [2*WIDTH-1:0] prod_s;
   logic [WIDTH-1:0]   res_hi_s, res_lo_s;

   assign busy = busy_r;
   assign done = done_r;
   assign hi   = hi_r;
   assign lo   = lo_r;

   // Operand conditioning, one datapath step, and final sign correction.
   always_comb begin
      idle_like_s = (state_r == IDLE) || (state_r == DONE);
      accept_s    = idle_like_s && start && en && !flush;
      signed_s    = ~op[0];
      a_abs_s     = (signed_s && port_a[WIDTH-1]) ? -port_a : port_a;
      b_abs_s     = (signed_s && port_b[WIDTH-1]) ? -port_b : port_b;
      shifted_s   = acc_r[2*WIDTH-1:WIDTH-1];
      diff_s      = shifted_s - {1'b0, mcand_r[WIDTH-1:0]};
      step_s      = acc_r;
      if (!op_r[1]) begin
         if (mplier_r[0]) begin
            step_s = acc_r + mcand_r;
         end else begin
            step_s = acc_r;
         end
      end else if (!diff_s[WIDTH]) begin
         step_s = {diff_s[WIDTH-1:0], acc_r[WIDTH-2:0], 1'b1};
      end else begin
         step_s = {acc_r[2*WIDTH-2:0], 1'b0};
      end
`ifdef MULDIV_EARLY_OUT_EN
      last_s = (cnt_r == CW'(1)) || (!op_r[1] && ((mplier_r >> 1) == '0));
`else
      last_s = (cnt_r == CW'(1));
`endif
      prod_s = neg_q_r ? -acc_r : acc_r;
      if (!op_r[1]) begin
         res_hi_s = prod_s[2*WIDTH-1:WIDTH];
         res_lo_s = prod_s[WIDTH-1:0];
      end else if (div0_r) begin
         res_hi_s = a_raw_r;
         res_lo_s = '1;
      end else begin
         res_hi_s = neg_r_r ? -acc_r[2*WIDTH-1:WIDTH] : acc_r[2*WIDTH-1:WIDTH];
         res_lo_s = neg_q_r ? -acc_r[WIDTH-1:0] : acc_r[WIDTH-1:0];
      end
   end

   // Control FSM, datapath registers and the architectural HI/LO state.
   always_ff @(posedge CLK or negedge nRST) begin
      if (!nRST) begin
         state_r  <= IDLE;
         cnt_r    <= '0;
         op_r     <= 2'b00;
         acc_r    <= '0;
         mcand_r  <= '0;
         mplier_r <= '0;
         a_raw_r  <= '0;
         neg_q_r  <= 1'b0;
         neg_r_r  <= 1'b0;
         div0_r   <= 1'b0;
         busy_r   <= 1'b0;
         done_r   <= 1'b0;
         hi_r     <= '0;
         lo_r     <= '0;
      end else begin
         if (idle_like_s && hi_we) begin
            hi_r <= wdat;
         end
         if (idle_like_s && lo_we) begin
            lo_r <= wdat;
         end
         case (state_r)
            IDLE, DONE: begin
               done_r <= 1'b0;
               if (accept_s) begin
                  state_r  <= CALC;
                  busy_r   <= 1'b1;
                  cnt_r    <= CW'(WIDTH);
                  op_r     <= op;
                  a_raw_r  <= port_a;
                  acc_r    <= {{WIDTH{1'b0}}, op[1] ? a_abs_s : {WIDTH{1'b0}}};
                  mcand_r  <= {{WIDTH{1'b0}}, op[1] ? b_abs_s : a_abs_s};
                  mplier_r <= b_abs_s;
                  neg_q_r  <= signed_s && (port_a[WIDTH-1] ^ port_b[WIDTH-1]);
                  neg_r_r  <= signed_s && port_a[WIDTH-1];
                  div0_r   <= (port_b == '0);
               end else begin
                  state_r <= IDLE;
                  busy_r  <= 1'b0;
               end
            end
            CALC: begin
               if (flush) begin
                  state_r <= IDLE;
                  busy_r  <= 1'b0;
               end else begin
                  acc_r    <= step_s;
                  mcand_r  <= op_r[1] ? mcand_r : (mcand_r << 1);
                  mplier_r <= mplier_r >> 1;
                  cnt_r    <= cnt_r - CW'(1);
                  state_r  <= last_s ? FIX : CALC;
               end
            end
            FIX: begin
               busy_r <= 1'b0;
               if (flush) begin
                  state_r <= IDLE;
               end else begin
                  hi_r    <= res_hi_s;
                  lo_r    <= res_lo_s;
                  state_r <= DONE;
                  done_r  <= 1'b1;
               end
            end
            default: begin
               state_r <= IDLE;
               busy_r  <= 1'b0;
               done_r  <= 1'b0;
            end
         endcase
      end
   end
endmodule
